// File: rtl/tohost_mon_pkg.sv
// Shared types and constants for the AXI tohost write monitor.
package tohost_mon_pkg;

    localparam int unsigned AXI_ADDR_W = 64;
    localparam int unsigned AXI_DATA_W = 64;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;
    localparam logic [1:0] RSVD  = 2'b11;

    localparam logic [63:0] PASS_CODE = 64'd1;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } aw_entry_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] data;
        logic [AXI_STRB_W-1:0] strb;
        logic                  last;
    } w_entry_t;

endpackage

// File: rtl/axi_tohost_monitor_if.sv
// Passive tap of the AXI4 write channels (AW, W, B) seen by the monitor.
interface axi_tohost_monitor_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid, awready,
        output wdata, wstrb, wlast, wvalid, wready,
        output bvalid, bready
    );

    modport slave (
        input awaddr, awlen, awsize, awburst, awvalid, awready,
        input wdata, wstrb, wlast, wvalid, wready,
        input bvalid, bready
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push while full is dropped and flagged on overflow.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             overflow
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Extra pointer MSB distinguishes full from empty when indices coincide.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign overflow = push && full;
    assign pop_data = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + CNT_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end
endmodule

// File: rtl/axi_tohost_monitor.sv
// Passive AXI4 write monitor: rebuilds beat addresses, captures the tohost
// word and reports done/pass/fail, timeout and protocol errors.
module axi_tohost_monitor
    import tohost_mon_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH     = 64,
    parameter int unsigned            DATA_WIDTH     = 64,
    parameter int unsigned            ID_WIDTH       = 4,
    parameter logic [ADDR_WIDTH-1:0]  TOHOST_ADDR    = ADDR_WIDTH'(64'h0000_0000_8000_1000),
    parameter int unsigned            AW_DEPTH       = 4,
    parameter int unsigned            W_DEPTH        = 8,
    parameter int unsigned            TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_tohost_monitor_if.slave  bus,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic [63:0]          exit_code,
    output logic                 timeout,
    output logic                 proto_err,
    output logic [31:0]          beat_cnt,
    output logic [31:0]          burst_cnt
);
    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned TCNT_W = 32;

    if (DATA_WIDTH != AXI_DATA_W || ADDR_WIDTH != AXI_ADDR_W || ID_WIDTH == 0 ||
        TOHOST_ADDR[2:0] != 3'b000 || AW_DEPTH < 2 || W_DEPTH < 2 ||
        (AW_DEPTH & (AW_DEPTH - 1)) != 0 || (W_DEPTH & (W_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("axi_tohost_monitor: unsupported parameterisation");
    end

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t            state;
    state_t            state_nxt;
    aw_entry_t         aw_in;
    aw_entry_t         aw_head;
    w_entry_t          w_in;
    w_entry_t          w_head;
    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;
    logic              aw_full;
    logic              aw_empty;
    logic              aw_ovf;
    logic              w_full;
    logic              w_empty;
    logic              w_ovf;
    logic              aw_pop_c;
    logic              w_pop_c;
    logic              last_err_c;
    logic              burst_err_c;
    logic              match_c;
    logic              fire_c;
    logic [ADDR_WIDTH-1:0] beat_addr_c;
    logic [ADDR_WIDTH-1:0] size_mask_c;
    logic [63:0]       merged_c;

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [7:0]        cur_len;
    logic [2:0]        cur_size;
    logic [1:0]        cur_burst;
    logic [7:0]        beat_idx;
    logic [63:0]       shadow;
    logic [TCNT_W-1:0] tcnt;

    assign aw_hs = bus.awvalid && bus.awready;
    assign w_hs  = bus.wvalid && bus.wready;
    assign b_hs  = bus.bvalid && bus.bready;
    assign aw_in = '{addr: bus.awaddr, len: bus.awlen, size: bus.awsize, burst: bus.awburst};
    assign w_in  = '{data: bus.wdata, strb: bus.wstrb, last: bus.wlast};

    sync_fifo #(.WIDTH($bits(aw_entry_t)), .DEPTH(AW_DEPTH)) u_aw_fifo (
        .clk(clk), .rst(rst), .push(aw_hs), .push_data(aw_in), .pop(aw_pop_c),
        .pop_data(aw_head), .full(aw_full), .empty(aw_empty), .overflow(aw_ovf)
    );

    sync_fifo #(.WIDTH($bits(w_entry_t)), .DEPTH(W_DEPTH)) u_w_fifo (
        .clk(clk), .rst(rst), .push(w_hs), .push_data(w_in), .pop(w_pop_c),
        .pop_data(w_head), .full(w_full), .empty(w_empty), .overflow(w_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Matcher: pair one AW with its W beats, one beat per cycle.
    always_comb begin
        state_nxt   = state;
        aw_pop_c    = 1'b0;
        w_pop_c     = 1'b0;
        last_err_c  = 1'b0;
        burst_err_c = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!aw_empty && !w_empty) begin
                    aw_pop_c    = 1'b1;
                    burst_err_c = (aw_head.burst == WRAP) || (aw_head.burst == RSVD);
                    state_nxt   = ST_BURST;
                end
            end
            ST_BURST: begin
                if (!w_empty) begin
                    w_pop_c    = 1'b1;
                    last_err_c = ((beat_idx == cur_len) != w_head.last);
                    if (beat_idx == cur_len || w_head.last) state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Beat address and tohost byte merge for the beat being popped.
    always_comb begin
        size_mask_c = (ADDR_WIDTH'(1) << cur_size) - ADDR_WIDTH'(1);
        if (cur_burst == FIXED || beat_idx == 8'd0)
            beat_addr_c = cur_addr;
        else
            beat_addr_c = (cur_addr & ~size_mask_c) + (ADDR_WIDTH'(beat_idx) << cur_size);
        match_c = w_pop_c && (beat_addr_c[ADDR_WIDTH-1:3] == TOHOST_ADDR[ADDR_WIDTH-1:3]);
        for (int b = 0; b < NBYTES; b++) begin
            merged_c[8*b +: 8] = w_head.strb[b] ? w_head.data[8*b +: 8] : shadow[8*b +: 8];
        end
        fire_c = match_c && (merged_c != 64'd0) && !done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr  <= '0;
            cur_len   <= '0;
            cur_size  <= '0;
            cur_burst <= INCR;
            beat_idx  <= '0;
            shadow    <= '0;
            tcnt      <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            exit_code <= '0;
            timeout   <= 1'b0;
            proto_err <= 1'b0;
            beat_cnt  <= '0;
            burst_cnt <= '0;
        end else begin
            if (aw_pop_c) begin
                cur_addr  <= aw_head.addr;
                cur_len   <= aw_head.len;
                cur_size  <= aw_head.size;
                cur_burst <= (aw_head.burst == FIXED) ? FIXED : INCR;
                beat_idx  <= 8'd0;
            end else if (w_pop_c) begin
                beat_idx  <= beat_idx + 8'd1;
            end
            if (match_c) shadow <= merged_c;
            if (fire_c) begin
                done      <= 1'b1;
                exit_code <= merged_c;
                pass      <= (merged_c == PASS_CODE);
                fail      <= (merged_c != PASS_CODE);
            end
            // A done arriving in the same cycle suppresses the timeout.
            if (TIMEOUT_CYCLES != 0 && !done && !timeout && !fire_c) begin
                tcnt <= tcnt + TCNT_W'(1);
                if (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1)) timeout <= 1'b1;
            end
            if (aw_ovf || w_ovf || burst_err_c || last_err_c) proto_err <= 1'b1;
            if (w_hs && beat_cnt != '1)  beat_cnt  <= beat_cnt + 32'd1;
            if (b_hs && burst_cnt != '1) burst_cnt <= burst_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_axi_tohost_monitor.sv
// Scoreboard bench for axi_tohost_monitor: expected tohost results are queued at stimulus time.
module tb_axi_tohost_monitor;
    import tohost_mon_pkg::*;

    localparam logic [63:0] TOHOST = 64'h0000_0000_8000_1000;

    typedef struct {
        logic [63:0] code;
        logic        pass;
        logic        fail;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        done;
    logic        pass;
    logic        fail;
    logic [63:0] exit_code;
    logic        timeout;
    logic        proto_err;
    logic [31:0] beat_cnt;
    logic [31:0] burst_cnt;

    int n_checks = 0;
    int n_errors = 0;
    exp_t sb[$];

    axi_tohost_monitor_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

    axi_tohost_monitor #(
        .ADDR_WIDTH(64), .DATA_WIDTH(64), .ID_WIDTH(4), .TOHOST_ADDR(TOHOST),
        .AW_DEPTH(4), .W_DEPTH(8), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .done(done), .pass(pass), .fail(fail),
        .exit_code(exit_code), .timeout(timeout), .proto_err(proto_err),
        .beat_cnt(beat_cnt), .burst_cnt(burst_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bvalid  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_aw(input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
        bus.awvalid = 1'b1;
    endtask

    task automatic set_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        bus.wdata = data; bus.wstrb = strb; bus.wlast = last;
        bus.wvalid = 1'b1;
    endtask

    task automatic push_exp(input logic [63:0] code);
        exp_t e;
        e.code = code;
        e.pass = (code == 64'd1);
        e.fail = (code != 64'd1);
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    // Wait (bounded) for done, then compare against the oldest queued expectation.
    task automatic wait_done(input string tag, input int budget);
        exp_t e;
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_code"}, exit_code, e.code);
            chk({tag, "_pass"}, 64'(pass), 64'(e.pass));
            chk({tag, "_fail"}, 64'(fail), 64'(e.fail));
        end
    endtask

    initial begin
        bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awvalid = 1'b0; bus.awready = 1'b1;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        bus.wvalid = 1'b0; bus.wready = 1'b1;
        bus.bvalid = 1'b0; bus.bready = 1'b1;
        #1;
        do_reset();

        chk("rst_done", 64'(done), 64'd0);
        chk("rst_exit", exit_code, 64'd0);
        chk("rst_proto", 64'(proto_err), 64'd0);
        chk("rst_beats", 64'(beat_cnt), 64'd0);

        // Single beat, AW and W together: done exactly three cycles later.
        set_aw(TOHOST, 8'd0, 3'd3, INCR);
        set_w(64'h1, 8'hFF, 1'b1);
        push_exp(64'h1);
        tick();
        tick();
        chk("single_lat2", 64'(done), 64'd0);
        tick();
        chk("single_lat3", 64'(done), 64'd1);
        wait_done("single", 1);

        // W ahead of its AW.
        do_reset();
        set_w(64'h7, 8'hFF, 1'b1);
        tick();
        idle(3);
        set_aw(TOHOST, 8'd0, 3'd3, INCR);
        push_exp(64'h7);
        tick();
        wait_done("w_first", 10);
        chk("w_first_proto", 64'(proto_err), 64'd0);

        // INCR burst crossing into tohost on beat 2.
        do_reset();
        set_aw(64'h8000_0FF0, 8'd3, 3'd3, INCR);
        set_w(64'h0, 8'hFF, 1'b0);
        push_exp(64'h1);
        tick();
        set_w(64'h0, 8'hFF, 1'b0); tick();
        set_w(64'h1, 8'hFF, 1'b0); tick();
        set_w(64'h0, 8'hFF, 1'b1); tick();
        wait_done("incr", 10);
        chk("incr_beats", 64'(beat_cnt), 64'd4);
        chk("incr_proto", 64'(proto_err), 64'd0);

        // Split 32-bit stores: upper half alone triggers done; later store is ignored.
        do_reset();
        set_aw(TOHOST, 8'd0, 3'd3, INCR);
        set_w(64'h5 << 32, 8'hF0, 1'b1);
        push_exp(64'h0000_0005_0000_0000);
        tick();
        wait_done("split", 10);
        set_aw(TOHOST, 8'd0, 3'd3, INCR);
        set_w(64'h0, 8'h0F, 1'b1);
        tick();
        bus.bvalid = 1'b1; tick();
        bus.bvalid = 1'b1; tick();
        idle(4);
        chk("split_frozen", exit_code, 64'h0000_0005_0000_0000);
        chk("split_fail", 64'(fail), 64'd1);
        chk("split_bursts", 64'(burst_cnt), 64'd2);

        // Reset clears sticky outputs and counters.
        rst = 1'b1;
        tick();
        chk("clr_done", 64'(done), 64'd0);
        chk("clr_fail", 64'(fail), 64'd0);
        chk("clr_exit", exit_code, 64'd0);
        chk("clr_bursts", 64'(burst_cnt), 64'd0);
        chk("clr_beats", 64'(beat_cnt), 64'd0);
        rst = 1'b0;

        // W FIFO overflow on the ninth unmatched beat.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_w(64'(i), 8'hFF, 1'b1);
            tick();
        end
        chk("ovf_8", 64'(proto_err), 64'd0);
        set_w(64'h9, 8'hFF, 1'b1);
        tick();
        chk("ovf_9", 64'(proto_err), 64'd1);
        chk("ovf_beats", 64'(beat_cnt), 64'd9);

        // Early wlast on a two-beat burst.
        do_reset();
        set_aw(64'h8000_2000, 8'd1, 3'd3, INCR);
        set_w(64'h0, 8'hFF, 1'b1);
        tick();
        idle(3);
        chk("early_last", 64'(proto_err), 64'd1);

        // WRAP burst flagged; address still treated as INCR so tohost beat matches.
        do_reset();
        set_aw(TOHOST, 8'd0, 3'd3, WRAP);
        set_w(64'h3, 8'hFF, 1'b1);
        push_exp(64'h3);
        tick();
        wait_done("wrap", 10);
        chk("wrap_proto", 64'(proto_err), 64'd1);

        // Timeout after exactly 50 post-reset cycles, then reset clears it.
        do_reset();
        idle(49);
        chk("tmo_49", 64'(timeout), 64'd0);
        tick();
        chk("tmo_50", 64'(timeout), 64'd1);
        rst = 1'b1;
        tick();
        chk("tmo_clr", 64'(timeout), 64'd0);
        chk("tmo_clr_proto", 64'(proto_err), 64'd0);
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=hang exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
